// File: rtl/des_key_schedule.sv
// ============================================================================
// Module   : des_key_schedule
// Purpose  : DES round-key expansion, one 48-bit subkey (K1..K16) per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module des_key_schedule #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [63:0] key_in,
  output logic        busy,
  output logic        key_ready,
  output logic [47:0] r1_key,
  output logic [47:0] r2_key,
  output logic [47:0] r3_key,
  output logic [47:0] r4_key,
  output logic [47:0] r5_key,
  output logic [47:0] r6_key,
  output logic [47:0] r7_key,
  output logic [47:0] r8_key,
  output logic [47:0] r9_key,
  output logic [47:0] r10_key,
  output logic [47:0] r11_key,
  output logic [47:0] r12_key,
  output logic [47:0] r13_key,
  output logic [47:0] r14_key,
  output logic [47:0] r15_key,
  output logic [47:0] r16_key
);

  // Tables hold FIPS 46-3 bit numbers (1 = MSB of the source word).
  localparam int PC1_TABLE [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_TABLE[6'(i)])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(56 - PC2_TABLE[6'(i)])];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] h, input logic two);
    return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  counter, counter_nx;
  logic [27:0] c_reg, d_reg, c_nx, d_nx, c_rot, d_rot;
  logic        busy_nx, ready_nx, key_we, two_shift;
  logic [47:0] subkey;
  logic [47:0] round_key [1:ROUNDS];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      counter   <= '0;
      c_reg     <= '0;
      d_reg     <= '0;
      busy      <= 1'b0;
      key_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      counter   <= counter_nx;
      c_reg     <= c_nx;
      d_reg     <= d_nx;
      busy      <= busy_nx;
      key_ready <= ready_nx;
    end
  end

  always_comb begin
    two_shift  = !((counter == 5'd1) || (counter == 5'd2) ||
                   (counter == 5'd9) || (counter == 5'd16));
    c_rot      = rotl(c_reg, two_shift);
    d_rot      = rotl(d_reg, two_shift);
    subkey     = pc2({c_rot, d_rot});
    state_nx   = state;
    counter_nx = counter;
    c_nx       = c_reg;
    d_nx       = d_reg;
    busy_nx    = busy;
    ready_nx   = key_ready;
    key_we     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          {c_nx, d_nx} = pc1(key_in);
          counter_nx   = 5'd1;
          ready_nx     = 1'b0;
          busy_nx      = 1'b1;
          state_nx     = GEN;
        end
      end
      GEN: begin
        c_nx   = c_rot;
        d_nx   = d_rot;
        key_we = 1'b1;
        if (counter == 5'(ROUNDS)) begin
          counter_nx = '0;
          ready_nx   = 1'b1;
          busy_nx    = 1'b0;
          state_nx   = IDLE;
        end else begin
          counter_nx = counter + 5'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Only the slot for the current round is written; others keep stale data.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 1; i <= ROUNDS; i++) begin
        round_key[i] <= '0;
      end
    end else if (key_we) begin
      round_key[counter] <= subkey;
    end
  end

  assign r1_key  = round_key[1];
  assign r2_key  = round_key[2];
  assign r3_key  = round_key[3];
  assign r4_key  = round_key[4];
  assign r5_key  = round_key[5];
  assign r6_key  = round_key[6];
  assign r7_key  = round_key[7];
  assign r8_key  = round_key[8];
  assign r9_key  = round_key[9];
  assign r10_key = round_key[10];
  assign r11_key = round_key[11];
  assign r12_key = round_key[12];
  assign r13_key = round_key[13];
  assign r14_key = round_key[14];
  assign r15_key = round_key[15];
  assign r16_key = round_key[16];

endmodule

`default_nettype wire

// File: tb/tb_des_key_schedule.sv
// ============================================================================
// Module   : tb_des_key_schedule
// Purpose  : Self-checking bench for des_key_schedule against a FIPS-table model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_des_key_schedule;

  localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PAR_KEY  = 64'h123456789ABCDEF0;
  localparam logic [63:0] PAR_MASK = 64'h0101010101010101;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [63:0] key_in;
  logic        busy, key_ready;
  logic [47:0] dut_k [1:16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  des_key_schedule #(.ROUNDS(16)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .key_in(key_in),
    .busy(busy), .key_ready(key_ready),
    .r1_key(dut_k[1]),   .r2_key(dut_k[2]),   .r3_key(dut_k[3]),   .r4_key(dut_k[4]),
    .r5_key(dut_k[5]),   .r6_key(dut_k[6]),   .r7_key(dut_k[7]),   .r8_key(dut_k[8]),
    .r9_key(dut_k[9]),   .r10_key(dut_k[10]), .r11_key(dut_k[11]), .r12_key(dut_k[12]),
    .r13_key(dut_k[13]), .r14_key(dut_k[14]), .r15_key(dut_k[15]), .r16_key(dut_k[16])
  );

  // Subkey n from first principles: C0/D0 rotated by the cumulative shift count.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int n);
    bit kb  [1:64];
    bit cd0 [1:56];
    bit cd  [1:56];
    int tot;
    logic [47:0] r;
    for (int i = 1; i <= 64; i++) kb[i] = key[64 - i];
    for (int i = 1; i <= 56; i++) cd0[i] = kb[PC1[i - 1]];
    tot = 0;
    for (int j = 0; j < n; j++) tot += SHIFTS[j];
    for (int i = 1; i <= 28; i++) begin
      cd[i]      = cd0[((i - 1 + tot) % 28) + 1];
      cd[28 + i] = cd0[28 + ((i - 1 + tot) % 28) + 1];
    end
    r = '0;
    for (int i = 1; i <= 48; i++) r[48 - i] = cd[PC2[i - 1]];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level expectation of what the outputs must show.
  logic        m_busy, m_ready;
  logic [63:0] m_key;
  int          m_n;
  logic [47:0] m_keys [1:16];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_busy = 1'b0; m_ready = 1'b0; m_n = 0;
      for (int i = 1; i <= 16; i++) m_keys[i] = '0;
    end else if (m_busy) begin
      m_keys[m_n] = ref_subkey(m_key, m_n);
      if (m_n == 16) begin
        m_busy = 1'b0; m_ready = 1'b1; m_n = 0;
      end else begin
        m_n++;
      end
    end else if (start) begin
      m_key = key_in; m_busy = 1'b1; m_ready = 1'b0; m_n = 1;
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      check("busy", {63'd0, busy}, {63'd0, m_busy});
      check("key_ready", {63'd0, key_ready}, {63'd0, m_ready});
      for (int i = 1; i <= 16; i++)
        check($sformatf("r%0d_key", i), {16'd0, dut_k[i]}, {16'd0, m_keys[i]});
    end
  end

  // Caller must be at a falling edge; the next rising edge samples start.
  task automatic do_start(input logic [63:0] k);
    key_in = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!key_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_timeout", {63'd0, key_ready}, 64'd1);
  endtask

  task automatic check_all_vs(input logic [63:0] key, input string tag);
    for (int i = 1; i <= 16; i++)
      check($sformatf("%s_k%0d", tag, i), {16'd0, dut_k[i]}, {16'd0, ref_subkey(key, i)});
  endtask

  int          lat;
  logic [47:0] saved [1:16];
  logic [63:0] rk;

  initial begin
    n_rst = 1'b0; start = 1'b0; key_in = '0;
    #1;
    check("por_busy", {63'd0, busy}, 64'd0);
    check("por_ready", {63'd0, key_ready}, 64'd0);
    check("por_r1", {16'd0, dut_k[1]}, 64'd0);
    check("por_r16", {16'd0, dut_k[16]}, 64'd0);

    // Pin the model to the published FIPS subkeys.
    check("model_k1", {16'd0, ref_subkey(FIPS_KEY, 1)}, 64'h00001B02EFFC7072);
    check("model_k2", {16'd0, ref_subkey(FIPS_KEY, 2)}, 64'h000079AED9DBC9E5);
    check("model_k16", {16'd0, ref_subkey(FIPS_KEY, 16)}, 64'h0000CB3D8B0E17F5);

    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // FIPS vector and latency
    do_start(FIPS_KEY);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    lat = 0;
    while (!key_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ready_latency", lat, 16);
    check("fips_r1", {16'd0, dut_k[1]}, 64'h00001B02EFFC7072);
    check("fips_r2", {16'd0, dut_k[2]}, 64'h000079AED9DBC9E5);
    check("fips_r16", {16'd0, dut_k[16]}, 64'h0000CB3D8B0E17F5);

    // Back-to-back with the all-zero key
    do_start(64'h0);
    check("b2b_ready_drop", {63'd0, key_ready}, 64'd0);
    check("b2b_busy", {63'd0, busy}, 64'd1);
    wait_ready(lat);
    for (int i = 1; i <= 16; i++)
      check($sformatf("zero_k%0d", i), {16'd0, dut_k[i]}, 64'd0);

    // Parity bits must not matter
    do_start(PAR_KEY);
    wait_ready(lat);
    for (int i = 1; i <= 16; i++) saved[i] = dut_k[i];
    check_all_vs(PAR_KEY, "par");
    do_start(PAR_KEY ^ PAR_MASK);
    wait_ready(lat);
    for (int i = 1; i <= 16; i++)
      check($sformatf("parflip_k%0d", i), {16'd0, dut_k[i]}, {16'd0, saved[i]});

    // Starts at E5 and E16 of a running expansion are ignored
    do_start(FIPS_KEY);
    repeat (4) @(negedge clk);
    do_start(64'hFFFF_FFFF_FFFF_FFFF);
    repeat (10) @(negedge clk);
    do_start(64'h0);
    check("prot_ready", {63'd0, key_ready}, 64'd1);
    @(negedge clk);
    check("prot_idle", {63'd0, busy}, 64'd0);
    check_all_vs(FIPS_KEY, "prot");

    // Reset in the middle of an expansion
    do_start(PAR_KEY);
    repeat (8) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_ready", {63'd0, key_ready}, 64'd0);
    for (int i = 1; i <= 16; i++)
      check($sformatf("mid_rst_k%0d", i), {16'd0, dut_k[i]}, 64'd0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    do_start(FIPS_KEY);
    lat = 0;
    while (!key_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("post_rst_latency", lat, 16);
    check_all_vs(FIPS_KEY, "post_rst");

    // Random keys; key_in is scrambled after acceptance
    for (int t = 0; t < 200; t++) begin
      rk = {$urandom, $urandom};
      do_start(rk);
      key_in = {$urandom, $urandom};
      wait_ready(lat);
      check_all_vs(rk, "rand");
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Generates the sixteen 48-bit DES round keys from one 64-bit key, producing one subkey per clock.
It sits directly upstream of the DES datapath and drives its r1_key..r16_key inputs.
key_ready is the qualifier the controller waits on before asserting the datapath enable.
Keys are always emitted in natural encryption order (K1 on r1_key); any reordering for decryption is done downstream.

Parameters:
ROUNDS, 16, number of round keys generated; fixed at 16, and any other value is unsupported.

Ports:
clk  input  1  system clock; all state updates on the rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  single-cycle request to expand key_in; accepted only when busy=0
key_in  input  64  DES key; FIPS 46-3 bit 1 = key_in[63]; parity bits (8,16,...,64) ignored
busy  output  1  high while expansion is in progress
key_ready  output  1  high when r1_key..r16_key all hold the subkeys of the last accepted key
r1_key..r16_key  output  48 each  round keys K1..K16; FIPS bit 1 = [47]

Behaviour:
- Reset (n_rst=0, asynchronous): state=IDLE, counter=0, C=0, D=0, every rN_key=0, busy=0, key_ready=0.
- State machine: IDLE, GEN.
- IDLE:
  - start=1 at edge E0: C,D <= PC-1(key_in) (28 bits each); counter <= 1; key_ready <= 0; busy <= 1; go to GEN.
  - start=0: hold all registers.
- GEN, per edge En, n = counter = 1..16:
  - Left-rotate C and D by shift(n): 1 for n in {1,2,9,16}, otherwise 2.
  - rn_key <= PC-2 of the rotated {C,D}; C,D <= rotated values; counter <= n+1.
- Completion at E16:
  - r16_key written; key_ready <= 1; busy <= 0; counter <= 0; go to IDLE.
  - After 28 total shifts C,D equal their PC-1 values again; no further rotation occurs in IDLE.
- Latency: key_ready first reads 1 in the cycle after E16 (16 edges after the accepting edge).
  - Subkey n becomes visible after En, so a consumer may start round 1 early but must not rely on it.
- key_ready stays high indefinitely until the next accepted start or a reset.
- start while busy=1 is ignored: key_in is not sampled and the running expansion is unaffected.
- start in the same cycle as the E16 completion edge is ignored, because busy is still 1 at that edge; it must be re-issued.
- key_in is sampled only at E0; changes afterwards have no effect.
- Accepted start: rN_key registers keep their old values until overwritten in turn. Only key_ready signals consistency.
- Reset mid-GEN: everything clears immediately per the reset values; no partial keys remain visible.
- PC-1, PC-2 and the shift schedule are exactly as in FIPS 46-3. They are pure bit selection, with no arithmetic.
- Register the outputs. There is no combinational path from start or key_in to any output.

Test Plan:
- Reset: assert n_rst=0 mid-run and at power-up -> busy=0, key_ready=0, all rN_key=0 asynchronously, with no clock needed.
- FIPS vector: key_in=64'h133457799BBCDFF1, pulse start -> busy high for 16 cycles, then key_ready=1.
  - Required: r1_key=48'h1B02EFFC7072, r2_key=48'h79AED9DBC9E5, r16_key=48'hCB3D8B0E17F5.
  - Check key_ready timing: rises exactly 16 edges after start.
- Parity independence: repeat with key_in=64'h123456789ABCDEF0 and with all parity bits flipped -> identical 16 subkeys.
- Busy protection: start a new key at E5 and E16 of an expansion -> both ignored; results match the first key, and busy falls normally.
- Back-to-back: start again the cycle after key_ready rises with key_in=64'h0 -> key_ready drops next cycle; all subkeys become 48'h0 after 16 edges.
- Reset mid-operation: n_rst pulse at E8, then a fresh start with the FIPS vector -> the full correct key set with normal latency.
- Scoreboard: 200 random keys against a reference key-schedule model; every subkey is compared when key_ready rises.
